sample_ntt_parse: RTL and testbench

- Consumer of the SHAKE128 output string produced by the sponge for matrix-A generation.
- Runs the Kyber Parse rejection sampler. Splits the byte stream into 3-byte triples, forms two 12-bit candidates per triple, and accepts candidates below q = 3329.
- Streams 256 accepted coefficients, one per cycle, over a ready/valid interface to the polynomial RAM writer.
- Flags failure if the string is exhausted before 256 coefficients are accepted.

---
 rtl/sample_ntt_parse.sv | 191 +++++++++++++++++++
 tb/tb_sample_ntt_parse.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_ntt_parse.sv
// Kyber Parse rejection sampler for matrix-A generation.
// Consumes a latched SHAKE128 output string as 3-byte triples. Each triple
// yields two 12-bit candidates (D1, then D2). Candidates below Q are streamed
// out one per cycle over a ready/valid interface until N_COEFF have been
// accepted, or until the string is exhausted, which is flagged as fail.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   start            one-cycle request, honoured only in IDLE or FIN
//   in_string        sponge output; byte i = in_string[8i+7:8i]
//   coeff_ready      downstream can accept a coefficient
//   coeff            accepted coefficient
//   coeff_idx        index of coeff within the polynomial
//   coeff_valid      coeff/coeff_idx valid
//   busy             high while LOAD/RUN/DRAIN
//   done             high from completion until the next accepted start
//   fail             string exhausted before N_COEFF accepted (valid with done)
module sample_ntt_parse #(
  parameter int unsigned IN_BYTES = 672,
  parameter int unsigned N_COEFF  = 256,
  parameter int unsigned Q        = 3329
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*IN_BYTES-1:0] in_string,
  input  logic                  coeff_ready,
  output logic [11:0]           coeff,
  output logic [7:0]            coeff_idx,
  output logic                  coeff_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  fail
);

  localparam int unsigned IN_W      = 8 * IN_BYTES;
  localparam int unsigned N_TRIPLES = IN_BYTES / 3;
  localparam int unsigned CW        = 12;
  localparam int unsigned IW        = 8;
  localparam int unsigned CNTW      = 9;
  localparam int unsigned PW        = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [IN_W-1:0] str_q, str_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            half_q, half_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CW-1:0]   coeff_q, coeff_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            fail_q, fail_d;

  // The string register is shifted down one triple at a time, so the
  // current triple always sits in the low 24 bits.
  logic [7:0]    b0_c, b1_c, b2_c;
  logic [CW-1:0] d1_c, d2_c, cand_c;
  logic          slot_free_c;

  always_comb begin
    b0_c        = str_q[7:0];
    b1_c        = str_q[15:8];
    b2_c        = str_q[23:16];
    d1_c        = {b1_c[3:0], b0_c};
    d2_c        = {b2_c, b1_c[7:4]};
    cand_c      = half_q ? d2_c : d1_c;
    slot_free_c = !valid_q || coeff_ready;
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    str_d   = str_q;
    ptr_d   = ptr_q;
    half_d  = half_q;
    count_d = count_q;
    coeff_d = coeff_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = done_q;
    fail_d  = fail_q;

    // A completed handshake frees the output slot unless refilled below.
    if (valid_q && coeff_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          str_d   = in_string;
          ptr_d   = '0;
          half_d  = 1'b0;
          count_d = '0;
          valid_d = 1'b0;
          done_d  = 1'b0;
          fail_d  = 1'b0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        if (ptr_q == PW'(N_TRIPLES)) begin
          fail_d  = 1'b1;
          state_d = S_DRAIN;
        end else if (slot_free_c) begin
          if (cand_c < CW'(Q)) begin
            coeff_d = cand_c;
            idx_d   = count_q[IW-1:0];
            valid_d = 1'b1;
            count_d = count_q + CNTW'(1);
            // Any candidates left after the last accept are discarded.
            if (count_q == CNTW'(N_COEFF - 1)) begin
              state_d = S_DRAIN;
            end
          end
          if (half_q) begin
            half_d = 1'b0;
            ptr_d  = ptr_q + PW'(1);
            str_d  = str_q >> 24;
          end else begin
            half_d = 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (!valid_q || coeff_ready) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      str_q   <= '0;
      ptr_q   <= '0;
      half_q  <= 1'b0;
      count_q <= '0;
      coeff_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      str_q   <= str_d;
      ptr_q   <= ptr_d;
      half_q  <= half_d;
      count_q <= count_d;
      coeff_q <= coeff_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign coeff       = coeff_q;
  assign coeff_idx   = idx_q;
  assign coeff_valid = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;

endmodule

// File: tb/tb_sample_ntt_parse.sv
// Directed bench for sample_ntt_parse: zero string, exhaustion, boundary
// candidates, backpressure, mid-run reset and restart after completion.
module tb_sample_ntt_parse;

  localparam int unsigned IN_BYTES = 672;
  localparam int unsigned IN_W     = 8 * IN_BYTES;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [IN_W-1:0] in_string;
  logic            coeff_ready;
  logic [11:0]     coeff;
  logic [7:0]      coeff_idx;
  logic            coeff_valid;
  logic            busy;
  logic            done;
  logic            fail;

  int n_checks = 0;
  int n_errors = 0;

  sample_ntt_parse dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_string  (in_string),
    .coeff_ready(coeff_ready),
    .coeff      (coeff),
    .coeff_idx  (coeff_idx),
    .coeff_valid(coeff_valid),
    .busy       (busy),
    .done       (done),
    .fail       (fail)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ready driver: constant 1, or a coin flip each cycle.
  logic rand_ready = 1'b0;
  initial begin
    coeff_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      coeff_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: records transfers and watches stalled outputs.
  logic        mon_clr = 1'b0;
  logic [11:0] got_c [256];
  logic [7:0]  got_i [256];
  int          n_xfer, n_vcyc, n_stall, hold_err, last_cyc;
  logic        prev_stall;
  logic [11:0] prev_c;
  logic [7:0]  prev_i;

  always @(negedge clk) begin
    if (mon_clr || rst) begin
      n_xfer = 0; n_vcyc = 0; n_stall = 0; hold_err = 0; last_cyc = 0;
      prev_stall = 1'b0; prev_c = '0; prev_i = '0;
    end else begin
      if (prev_stall && (!coeff_valid || coeff !== prev_c || coeff_idx !== prev_i))
        hold_err = hold_err + 1;
      if (coeff_valid) n_vcyc = n_vcyc + 1;
      if (coeff_valid && coeff_ready) begin
        if (n_xfer < 256) begin
          got_c[n_xfer] = coeff;
          got_i[n_xfer] = coeff_idx;
        end
        n_xfer   = n_xfer + 1;
        last_cyc = cyc;
      end
      prev_stall = coeff_valid && !coeff_ready;
      if (prev_stall) n_stall = n_stall + 1;
      prev_c = coeff;
      prev_i = coeff_idx;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1 mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  // Returns just after the edge that samples start (edge 0).
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int done_cyc);
    int i;
    done_cyc = -1;
    for (i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_timeout", 32'(done), 32'd1);
    done_cyc = cyc;
  endtask

  task automatic wait_xfer(input int n);
    for (int i = 0; i < 3000 && n_xfer < n; i++) @(negedge clk);
    check("xfer_timeout", 32'(n_xfer >= n), 32'd1);
  endtask

  // Expected: coefficient 0 holds first_c, the rest are zero, idx in order.
  task automatic verify_seq(input string tag, input logic [11:0] first_c);
    for (int i = 0; i < 256; i++) begin
      check({tag, "_idx"}, 32'(got_i[i]), 32'(i));
      check({tag, "_coeff"}, 32'(got_c[i]), (i == 0) ? 32'(first_c) : 32'd0);
    end
  endtask

  logic [IN_W-1:0] str3;
  int dcyc, c0;

  initial begin
    rst = 1'b1; start = 1'b0; in_string = '0;
    str3 = '0;
    str3[7:0]   = 8'h01;
    str3[15:8]  = 8'h0D;
    str3[23:16] = 8'hD0;

    // Reset state
    @(negedge clk);
    check("rst_valid", 32'(coeff_valid), 32'd0);
    check("rst_coeff", 32'(coeff), 32'd0);
    check("rst_idx", 32'(coeff_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // All-zero string, ready held high
    in_string = '0;
    clear_mon();
    pulse_start();
    @(negedge clk);
    check("z_e0_busy", 32'(busy), 32'd1);
    check("z_e0_valid", 32'(coeff_valid), 32'd0);
    @(negedge clk);
    check("z_e1_valid", 32'(coeff_valid), 32'd0);
    @(negedge clk);
    check("z_e2_valid", 32'(coeff_valid), 32'd1);
    check("z_e2_idx", 32'(coeff_idx), 32'd0);
    wait_done(600, dcyc);
    check("z_fail", 32'(fail), 32'd0);
    check("z_busy", 32'(busy), 32'd0);
    check("z_xfers", 32'(n_xfer), 32'd256);
    check("z_vcycles", 32'(n_vcyc), 32'd256);
    check("z_done_lat", 32'(dcyc - last_cyc), 32'd1);
    verify_seq("z", 12'd0);

    // Restart from FIN with D1 = 3329 (rejected), D2 = 3328 (accepted);
    // a start pulse mid-run must be ignored.
    in_string = str3;
    clear_mon();
    pulse_start();
    @(negedge clk);
    check("r_done_clr", 32'(done), 32'd0);
    check("r_busy", 32'(busy), 32'd1);
    wait_xfer(50);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(600, dcyc);
    check("r_fail", 32'(fail), 32'd0);
    check("r_xfers", 32'(n_xfer), 32'd256);
    verify_seq("r", 12'd3328);

    // All-0xFF string: nothing accepted, exhaustion after 448 candidates
    in_string = '1;
    clear_mon();
    pulse_start();
    @(negedge clk);
    c0 = cyc;
    wait_done(800, dcyc);
    check("ff_fail", 32'(fail), 32'd1);
    check("ff_vcycles", 32'(n_vcyc), 32'd0);
    check("ff_busy", 32'(busy), 32'd0);
    check("ff_lat_range", 32'((dcyc - c0) >= 449 && (dcyc - c0) <= 452), 32'd1);

    // Backpressure with the all-zero string
    in_string = '0;
    rand_ready = 1'b1;
    clear_mon();
    pulse_start();
    wait_done(3000, dcyc);
    rand_ready = 1'b0;
    check("bp_fail", 32'(fail), 32'd0);
    check("bp_xfers", 32'(n_xfer), 32'd256);
    check("bp_hold_err", 32'(hold_err), 32'd0);
    check("bp_stalled", 32'(n_stall > 0), 32'd1);
    verify_seq("bp", 12'd0);

    // Reset after 100 handshakes, then a clean rerun
    clear_mon();
    pulse_start();
    wait_xfer(100);
    #2 rst = 1'b1;
    #1;
    check("mr_valid", 32'(coeff_valid), 32'd0);
    check("mr_coeff", 32'(coeff), 32'd0);
    check("mr_idx", 32'(coeff_idx), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_fail", 32'(fail), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
    pulse_start();
    wait_done(600, dcyc);
    check("mr2_fail", 32'(fail), 32'd0);
    check("mr2_xfers", 32'(n_xfer), 32'd256);
    verify_seq("mr2", 12'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
